// File: rtl/omni_pkg.sv
// Shared definitions for the omni dispatcher slice: header layout, default
// beat width, FSM encoding and the route-select helper.
package omni_pkg;

   localparam int HDR_W     = 16;
   localparam int LAST_BIT  = 15;
   localparam int DEST_LSB  = 0;
   localparam int DEST_W    = 8;
   localparam int DEF_WIDTH = 528;

   typedef enum logic {
      IDLE = 1'b0,
      BODY = 1'b1
   } state_t;

   // Full-width dest compare: any dest outside the slot range goes to loopback.
   function automatic logic [DEST_W-1:0] route_sel(input logic [DEST_W-1:0] dest,
                                                   input int num_slots);
      if (int'(dest) < num_slots) begin
         return dest;
      end
      return DEST_W'(num_slots);
   endfunction

endpackage

// File: rtl/omni_skid_buf.sv
// Two-entry register slice carrying {data, port}; registered ready on the
// input side, registered data/valid on the output side.
module omni_skid_buf
   import omni_pkg::*;
#(
   parameter int DATA_W = DEF_WIDTH,
   parameter int PORT_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic [PORT_W-1:0] in_port,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [PORT_W-1:0] out_port,
   output logic              out_valid,
   input  logic              out_ready
);

   logic [DATA_W-1:0] head_data_reg, head_data_next;
   logic [PORT_W-1:0] head_port_reg, head_port_next;
   logic [DATA_W-1:0] tail_data_reg, tail_data_next;
   logic [PORT_W-1:0] tail_port_reg, tail_port_next;
   logic [1:0]        count_reg, count_next;
   logic              ready_reg, ready_next;
   logic              push;
   logic              pop;

   assign push = in_valid & ready_reg;
   assign pop  = (count_reg != 2'd0) & out_ready;

   always_comb begin
      head_data_next = head_data_reg;
      head_port_next = head_port_reg;
      tail_data_next = tail_data_reg;
      tail_port_next = tail_port_reg;
      count_next     = count_reg;
      case (count_reg)
         2'd0: begin
            if (push) begin
               head_data_next = in_data;
               head_port_next = in_port;
               count_next     = 2'd1;
            end
         end
         2'd1: begin
            if (push && pop) begin
               head_data_next = in_data;
               head_port_next = in_port;
            end else if (push) begin
               tail_data_next = in_data;
               tail_port_next = in_port;
               count_next     = 2'd2;
            end else if (pop) begin
               count_next     = 2'd0;
            end
         end
         default: begin
            // Full: ready is low, so only a drain can happen here.
            if (pop) begin
               head_data_next = tail_data_reg;
               head_port_next = tail_port_reg;
               count_next     = 2'd1;
            end
         end
      endcase
      ready_next = (count_next != 2'd2);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_data_reg <= '0;
         head_port_reg <= '0;
         tail_data_reg <= '0;
         tail_port_reg <= '0;
         count_reg     <= 2'd0;
         ready_reg     <= 1'b0;
      end else begin
         head_data_reg <= head_data_next;
         head_port_reg <= head_port_next;
         tail_data_reg <= tail_data_next;
         tail_port_reg <= tail_port_next;
         count_reg     <= count_next;
         ready_reg     <= ready_next;
      end
   end

   assign in_ready  = ready_reg;
   assign out_data  = head_data_reg;
   assign out_port  = head_port_reg;
   assign out_valid = (count_reg != 2'd0);

endmodule

// File: rtl/omni_dispatcher.sv
// Packet demultiplexer: routes each packet to a slot port or loopback.
// Optional misroute counter enabled by OMNI_DISPATCH_MISROUTE_CNT_EN.
module omni_dispatcher
   import omni_pkg::*;
#(
   parameter int NUM_SLOTS = 2,
   parameter int WIDTH     = DEF_WIDTH,
   parameter int HDR_W     = omni_pkg::HDR_W
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [WIDTH-1:0]               rx_TDATA,
   input  logic                           rx_TVALID,
   output logic                           rx_TREADY,
   output logic [(NUM_SLOTS+1)*WIDTH-1:0] tx_TDATA,
   output logic [NUM_SLOTS:0]             tx_TVALID,
   input  logic [NUM_SLOTS:0]             tx_TREADY,
   output logic [31:0]                    misroute_cnt
);

   localparam int NUM_PORTS = NUM_SLOTS + 1;
   localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int HDR_LSB   = WIDTH - HDR_W;

   logic                rx_last;
   logic [DEST_W-1:0]   rx_dest;
   logic                accept;
   state_t              state_reg, state_next;
   logic [PORT_W-1:0]   route_reg, route_next;
   logic [PORT_W-1:0]   beat_port;
   logic [WIDTH-1:0]    buf_data;
   logic [PORT_W-1:0]   buf_port;
   logic                buf_valid;
   logic                buf_ready;
   logic [NUM_PORTS-1:0] port_hit;

   assign rx_last = rx_TDATA[HDR_LSB + LAST_BIT];
   assign rx_dest = rx_TDATA[HDR_LSB + DEST_LSB +: DEST_W];
   assign accept  = rx_TVALID & rx_TREADY;

   // Head beats decode their own dest; body beats reuse the latched route.
   always_comb begin
      state_next = state_reg;
      route_next = route_reg;
      beat_port  = route_reg;
      if (state_reg == IDLE) begin
         beat_port = PORT_W'(route_sel(rx_dest, NUM_SLOTS));
      end
      if (accept) begin
         route_next = beat_port;
         state_next = rx_last ? IDLE : BODY;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         route_reg <= '0;
      end else begin
         state_reg <= state_next;
         route_reg <= route_next;
      end
   end

   omni_skid_buf #(
      .DATA_W (WIDTH),
      .PORT_W (PORT_W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (rx_TDATA),
      .in_port   (beat_port),
      .in_valid  (rx_TVALID),
      .in_ready  (rx_TREADY),
      .out_data  (buf_data),
      .out_port  (buf_port),
      .out_valid (buf_valid),
      .out_ready (buf_ready)
   );

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign port_hit[gi] = (buf_port == PORT_W'(gi));
      assign tx_TDATA[gi*WIDTH +: WIDTH] = buf_data;
   end

   // Only the ready of the port owning the head entry matters.
   assign tx_TVALID = port_hit & {NUM_PORTS{buf_valid}};
   assign buf_ready = |(port_hit & tx_TREADY);

`ifdef OMNI_DISPATCH_MISROUTE_CNT_EN
   logic [31:0] misroute_cnt_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         misroute_cnt_reg <= '0;
      end else if (accept && (state_reg == IDLE) && (int'(rx_dest) >= NUM_SLOTS)) begin
         misroute_cnt_reg <= misroute_cnt_reg + 32'd1;
      end
   end

   assign misroute_cnt = misroute_cnt_reg;
`else
   assign misroute_cnt = '0;
`endif

endmodule

// File: tb/tb_omni_dispatcher.sv
// Directed bench for omni_dispatcher: hand-computed routes, backpressure,
// loopback/misroute and mid-packet reset, with an output-side scoreboard.
module tb_omni_dispatcher;
   import omni_pkg::*;

   localparam int NUM_SLOTS = 2;
   localparam int WIDTH     = 528;
   localparam int NP        = NUM_SLOTS + 1;
   localparam int CW        = 528;
`ifdef OMNI_DISPATCH_MISROUTE_CNT_EN
   localparam int MIS_EN = 1;
`else
   localparam int MIS_EN = 0;
`endif

   logic                clk = 1'b0;
   logic                rst_n;
   logic [WIDTH-1:0]    rx_TDATA;
   logic                rx_TVALID;
   logic                rx_TREADY;
   logic [NP*WIDTH-1:0] tx_TDATA;
   logic [NP-1:0]       tx_TVALID;
   logic [NP-1:0]       tx_TREADY;
   logic [31:0]         misroute_cnt;

   typedef struct {
      logic [WIDTH-1:0] data;
      int               port;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   logic             prev_stall = 1'b0;
   logic             prev_rst_n = 1'b0;
   logic [NP-1:0]    prev_valid = '0;
   logic [WIDTH-1:0] prev_data  = '0;

   omni_dispatcher #(
      .NUM_SLOTS (NUM_SLOTS),
      .WIDTH     (WIDTH),
      .HDR_W     (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_TDATA     (rx_TDATA),
      .rx_TVALID    (rx_TVALID),
      .rx_TREADY    (rx_TREADY),
      .tx_TDATA     (tx_TDATA),
      .tx_TVALID    (tx_TVALID),
      .tx_TREADY    (tx_TREADY),
      .misroute_cnt (misroute_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [511:0] mk_pay(input logic [31:0] seed);
      logic [511:0] p;
      for (int i = 0; i < 16; i++) begin
         p[i*32 +: 32] = seed + 32'h9E3779B9 * 32'(i);
      end
      return p;
   endfunction

   // Entered and left at posedge+1; pushes the expected beat once accepted.
   task automatic send(input logic [15:0] hdr, input logic [511:0] pay,
                       input int exp_port, output int stalls);
      rx_TDATA  = {hdr, pay};
      rx_TVALID = 1'b1;
      stalls    = 0;
      while (!rx_TREADY && stalls < 50) begin
         @(posedge clk); #1;
         stalls++;
      end
      if (!rx_TREADY) begin
         check_eq("accept_timeout", CW'(0), CW'(1));
      end else begin
         exp_q.push_back('{data: {hdr, pay}, port: exp_port});
         @(posedge clk); #1;
      end
      rx_TVALID = 1'b0;
   endtask

   task automatic drain(input string tag);
      rx_TVALID = 1'b0;
      tx_TREADY = '1;
      repeat (4) begin
         @(posedge clk); #1;
      end
      check_eq({tag, "_queue_empty"}, CW'(exp_q.size()), CW'(0));
      check_eq({tag, "_idle_valid"}, CW'(tx_TVALID), CW'(0));
   endtask

   task automatic monitor_step();
      int            obs;
      exp_t          e;
      logic [NP-1:0] xfer;
      if (prev_stall && prev_rst_n && rst_n) begin
         check_eq("hold_valid", CW'(tx_TVALID), CW'(prev_valid));
         check_eq("hold_data", tx_TDATA[WIDTH-1:0], prev_data);
      end
      if (rst_n && (tx_TVALID != '0)) begin
         check_eq("valid_onehot", CW'($onehot(tx_TVALID)), CW'(1));
         xfer = tx_TVALID & tx_TREADY;
         if (xfer != '0) begin
            obs = 0;
            for (int i = 0; i < NP; i++) begin
               if (xfer[i]) obs = i;
            end
            if (exp_q.size() == 0) begin
               check_eq("extra_beat", CW'(1), CW'(0));
            end else begin
               e = exp_q.pop_front();
               $display("[%0t] beat out port %0d hdr %h", $time, obs,
                        tx_TDATA[obs*WIDTH + WIDTH - 16 +: 16]);
               check_eq("beat_port", CW'(obs), CW'(e.port));
               check_eq("beat_data", tx_TDATA[obs*WIDTH +: WIDTH], e.data);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      monitor_step();
      prev_stall <= (tx_TVALID != '0) && ((tx_TVALID & tx_TREADY) == '0);
      prev_valid <= tx_TVALID;
      prev_data  <= tx_TDATA[WIDTH-1:0];
      prev_rst_n <= rst_n;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      int st_sum;
      logic [511:0] pay_a5;
      logic [511:0] pay_a;
      pay_a5    = {64{8'hA5}};
      rst_n     = 1'b0;
      rx_TDATA  = '0;
      rx_TVALID = 1'b0;
      tx_TREADY = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_tx_valid", CW'(tx_TVALID), CW'(0));
      check_eq("rst_rx_ready", CW'(rx_TREADY), CW'(0));
      check_eq("rst_tx_data0", tx_TDATA[WIDTH-1:0], CW'(0));
      check_eq("rst_misroute", CW'(misroute_cnt), CW'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq("rel_rx_ready", CW'(rx_TREADY), CW'(1));

      // Single-beat packet to slot 1, one-cycle latency
      tx_TREADY = '1;
      send(16'h8001, pay_a5, 1, st);
      check_eq("single_stall", CW'(st), CW'(0));
      check_eq("single_valid", CW'(tx_TVALID), CW'(3'b010));
      check_eq("single_data1", tx_TDATA[WIDTH +: WIDTH], {16'h8001, pay_a5});
      check_eq("single_data2", tx_TDATA[2*WIDTH +: WIDTH], {16'h8001, pay_a5});
      drain("single");

      // 4-beat packet to slot 0, body dest ignored, then back-to-back to slot 1
      st_sum = 0;
      send(16'h0000, mk_pay(32'h100), 0, st); st_sum += st;
      send(16'h0001, mk_pay(32'h101), 0, st); st_sum += st;
      send(16'h0001, mk_pay(32'h102), 0, st); st_sum += st;
      send(16'h8001, mk_pay(32'h103), 0, st); st_sum += st;
      send(16'h8001, mk_pay(32'h104), 1, st); st_sum += st;
      check_eq("stream_no_bubble", CW'(st_sum), CW'(0));
      check_eq("stream_last_valid", CW'(tx_TVALID), CW'(3'b010));
      drain("stream");

      // Loopback: dest 5, dest == NUM_SLOTS, and dest 4 (must not truncate)
      send(16'h0005, mk_pay(32'h200), 2, st);
      check_eq("mis_after_head", CW'(misroute_cnt), CW'(MIS_EN * 1));
      send(16'h8003, mk_pay(32'h201), 2, st);
      check_eq("mis_after_body", CW'(misroute_cnt), CW'(MIS_EN * 1));
      send(16'h8002, mk_pay(32'h202), 2, st);
      send(16'h8004, mk_pay(32'h203), 2, st);
      check_eq("mis_after_3", CW'(misroute_cnt), CW'(MIS_EN * 3));
      send(16'h8001, mk_pay(32'h204), 1, st);
      check_eq("mis_slot_no_inc", CW'(misroute_cnt), CW'(MIS_EN * 3));
      drain("loopback");

      // Backpressure on slot 0 while slot 1 is ready but unused
      tx_TREADY = 3'b110;
      pay_a = mk_pay(32'h300);
      send(16'h0000, pay_a, 0, st);
      check_eq("bp_ready_one", CW'(rx_TREADY), CW'(1));
      send(16'h0000, mk_pay(32'h301), 0, st);
      check_eq("bp_ready_full", CW'(rx_TREADY), CW'(0));
      rx_TDATA  = {16'h0000, mk_pay(32'h302)};
      rx_TVALID = 1'b1;
      for (int c = 0; c < 5; c++) begin
         check_eq("bp_hold_ready", CW'(rx_TREADY), CW'(0));
         check_eq("bp_hold_valid", CW'(tx_TVALID), CW'(3'b001));
         check_eq("bp_hold_data", tx_TDATA[WIDTH-1:0], {16'h0000, pay_a});
         @(posedge clk); #1;
      end
      tx_TREADY = '1;
      send(16'h0000, mk_pay(32'h302), 0, st);
      send(16'h8000, mk_pay(32'h303), 0, st);
      drain("backpressure");

      // Reset in the middle of a 4-beat packet to slot 1
      tx_TREADY = '0;
      send(16'h0001, mk_pay(32'h400), 1, st);
      send(16'h0000, mk_pay(32'h401), 1, st);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_eq("mid_rst_valid", CW'(tx_TVALID), CW'(0));
      check_eq("mid_rst_ready", CW'(rx_TREADY), CW'(0));
      check_eq("mid_rst_data0", tx_TDATA[WIDTH-1:0], CW'(0));
      check_eq("mid_rst_data1", tx_TDATA[WIDTH +: WIDTH], CW'(0));
      check_eq("mid_rst_misroute", CW'(misroute_cnt), CW'(0));
      exp_q.delete();
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq("mid_rel_ready", CW'(rx_TREADY), CW'(1));
      tx_TREADY = '1;
      send(16'h8000, mk_pay(32'h402), 0, st);
      check_eq("mid_head_valid", CW'(tx_TVALID), CW'(3'b001));
      drain("midreset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/omni_dispatcher.md
Name: omni_dispatcher

Overview:
- Packet-level demultiplexer feeding the per-slot paths that converge on the omni collector.
- Takes one AXI-Stream-style input of 512-bit payload plus 16-bit header. Routes each packet to one of NUM_SLOTS slot outputs, or to the loopback output (index NUM_SLOTS).
- Destination is latched from the first beat; the route is held until the beat whose last bit is 1.
- Registered, full-throughput output via a 2-entry skid buffer.

Parameters:
- NUM_SLOTS, 2, number of slot outputs; loopback is output index NUM_SLOTS.
- WIDTH, 528, beat width (512 payload + 16 header); must be > 16.
- HDR_W, 16, header width; header = TDATA[WIDTH-1 -: HDR_W].

Ports:
- clk  in  1  kernel clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- rx_TDATA  in  WIDTH  input beat.
- rx_TVALID  in  1  input valid.
- rx_TREADY  out  1  input ready.
- tx_TDATA  out  (NUM_SLOTS+1)*WIDTH  per-port data; all ports carry the same registered beat.
- tx_TVALID  out  NUM_SLOTS+1  one-hot or zero.
- tx_TREADY  in  NUM_SLOTS+1  per-port ready.
- misroute_cnt  out  32  packets redirected to loopback (counter feature only).

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous, active-low.
- Header fields:
  - hdr[15] = last.
  - hdr[7:0] = dest.
  - hdr[14:8] reserved; passed through unchanged.
  - Payload passed through unmodified. tx_TDATA beat is bit-identical to the accepted rx_TDATA beat.
- Route select: dest < NUM_SLOTS -> port dest; otherwise -> port NUM_SLOTS (loopback).
- Route decode uses full 8-bit dest compare. No truncation to $clog2 bits.
- FSM:
  - IDLE: next accepted beat is a packet head. Latch route. If last=0 -> BODY; if last=1 (single-beat packet) stay IDLE.
  - BODY: accepted beats use the latched route; the dest field of body beats is ignored. Accepted beat with last=1 -> IDLE.
- Handshake:
  - Input accept = rx_TVALID & rx_TREADY.
  - rx_TREADY = skid buffer not full. It is a registered signal, with no combinational path from tx_TREADY.
  - Output transfer = tx_TVALID[p] & tx_TREADY[p] on the routed port p.
  - tx_TREADY of non-selected ports is ignored.
- Latency: 1 cycle from accept to tx_TVALID when the buffer is empty.
- Throughput: 1 beat/cycle sustained while the selected tx_TREADY=1.
- Skid buffer:
  - Each entry stores {beat, port}.
  - Back-to-back packets to different ports are legal; ordering is preserved.
  - Never stall the input on a port change.
- Full: 2 entries held -> rx_TREADY=0 the next cycle. Accept and output transfer in the same cycle keep occupancy constant.
- Empty: tx_TVALID = 0.
- Reset values: tx_TVALID=0, rx_TREADY=0 during reset and 1 in the first cycle after reset release, FSM=IDLE, buffer empty, misroute_cnt=0, tx_TDATA=0.
- Reset mid-packet: in-flight beats are discarded. The first beat after reset is treated as a packet head.
- tx_TVALID must not drop, and tx_TDATA must not change, while tx_TVALID=1 and the selected tx_TREADY=0.

Optional Feature:
- Macro: OMNI_DISPATCH_MISROUTE_CNT_EN.
- Defined:
  - misroute_cnt increments by 1 on each accepted head beat with dest >= NUM_SLOTS.
  - Wraps at 2^32-1 -> 0.
  - Reset to 0.
- Undefined:
  - Counter logic absent; misroute_cnt is tied to 0.
  - Port still present, to keep the interface stable.

Decomposition:
- Shared package omni_pkg holds:
  - HDR_W.
  - Header bit positions: LAST_BIT=15, DEST_LSB=0, DEST_W=8.
  - Default WIDTH=528.
  - State encoding IDLE=0, BODY=1.
- Sub-module omni_skid_buf: 2-entry register slice carrying {WIDTH data, port index}, with valid/ready on both sides; reused elsewhere on slot paths.

Test Plan:
- Single-beat packet, hdr=16'h8001, payload 512'hA5..: tx_TVALID=3'b010 one cycle after accept, data bit-identical; FSM stays IDLE.
- 4-beat packet, dest=0; body beats carry dest=1: all 4 beats exit on port 0. Next packet with dest=1 goes to port 1 with no bubble.
- dest=8'h05 with NUM_SLOTS=2: all beats exit on port 2 (loopback). With the macro defined, misroute_cnt 0->1 after the head beat.
- tx_TREADY[0] held 0 for 5 cycles during a continuous stream to port 0: rx_TREADY=0 after 2 accepted beats; tx data stable; no beat lost or duplicated after release.
- tx_TREADY[1]=1 but traffic routed to port 0 with tx_TREADY[0]=0: no transfer; port 1 never asserts valid.
- rst_n=0 for 1 cycle mid-packet (beat 2 of 4): outputs reset as specified. The next beat, hdr=16'h8000, is routed as a head to port 0.
